// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver: glyphs, converter
// controller states and the power-of-ten helper used for the overflow limit.
package seg_pkg;

    // Active-low segment patterns, bit7 = dp, bits6..0 = g..a
    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_LO,
        ST_CONV_LO,
        ST_LOAD_HI,
        ST_CONV_HI
    } conv_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle,
// VALUE_W cycles per conversion, done pulses for one cycle at the end.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VALUE_W      = 32,
    parameter int FIELD_DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [VALUE_W-1:0]        bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*FIELD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * FIELD_DIGITS;
    localparam int REG_W = BCD_W + VALUE_W;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [REG_W-1:0] shift_reg;
    logic [REG_W-1:0] adjusted;
    logic [CNT_W-1:0] count_reg;
    logic             busy_reg;
    logic             done_reg;

    // Correct every BCD nibble that would carry out after the next doubling
    always_comb begin
        adjusted = shift_reg;
        for (int i = 0; i < FIELD_DIGITS; i++) begin
            if (shift_reg[VALUE_W+4*i +: 4] >= 4'd5) begin
                adjusted[VALUE_W+4*i +: 4] = shift_reg[VALUE_W+4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                shift_reg <= {{BCD_W{1'b0}}, bin};
                count_reg <= CNT_W'(VALUE_W);
                busy_reg  <= 1'b1;
            end else if (busy_reg) begin
                shift_reg <= {adjusted[REG_W-2:0], 1'b0};
                count_reg <= count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = shift_reg[REG_W-1 -: BCD_W];

endmodule

// File: rtl/seg_scan_driver.sv
// Two-field multiplexed 7-segment driver: a shared sequential BCD converter
// refreshes the displayed digits while a tick counter walks the common anodes.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int FIELD_DIGITS = 4,
    parameter int VALUE_W      = 32,
    parameter int SCAN_TICKS   = 100000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [VALUE_W-1:0]          value_lo,
    input  logic [VALUE_W-1:0]          value_hi,
    input  logic                        blank_lo,
    input  logic                        blank_hi,
    input  logic [2*FIELD_DIGITS-1:0]   dp_mask,
    output logic [7:0]                  seg,
    output logic [2*FIELD_DIGITS-1:0]   an
);

    localparam int N     = 2 * FIELD_DIGITS;
    localparam int BCD_W = 4 * FIELD_DIGITS;
    localparam int CNT_W = $clog2(SCAN_TICKS);
    localparam int IDX_W = $clog2(N);
    localparam logic [63:0] OVF_LIMIT = pow10(FIELD_DIGITS) - 64'd1;

    conv_state_t        state_reg;
    logic [VALUE_W-1:0] shadow_reg;
    logic               start_reg;
    logic               ovf_pend_reg;
    logic [BCD_W-1:0]   disp_lo_reg;
    logic [BCD_W-1:0]   disp_hi_reg;
    logic               ovf_lo_reg;
    logic               ovf_hi_reg;

    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    bin2bcd_seq #(
        .VALUE_W      (VALUE_W),
        .FIELD_DIGITS (FIELD_DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (start_reg),
        .bin   (shadow_reg),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Display registers only change on done, so a field swaps all digits at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            shadow_reg   <= '0;
            start_reg    <= 1'b0;
            ovf_pend_reg <= 1'b0;
            disp_lo_reg  <= '0;
            disp_hi_reg  <= '0;
            ovf_lo_reg   <= 1'b0;
            ovf_hi_reg   <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_LOAD_LO;
                end
                ST_LOAD_LO: begin
                    if (!conv_busy) begin
                        shadow_reg   <= value_lo;
                        ovf_pend_reg <= 64'(value_lo) > OVF_LIMIT;
                        start_reg    <= 1'b1;
                        state_reg    <= ST_CONV_LO;
                    end
                end
                ST_CONV_LO: begin
                    if (conv_done) begin
                        disp_lo_reg <= conv_bcd;
                        ovf_lo_reg  <= ovf_pend_reg;
                        state_reg   <= ST_LOAD_HI;
                    end
                end
                ST_LOAD_HI: begin
                    if (!conv_busy) begin
                        shadow_reg   <= value_hi;
                        ovf_pend_reg <= 64'(value_hi) > OVF_LIMIT;
                        start_reg    <= 1'b1;
                        state_reg    <= ST_CONV_HI;
                    end
                end
                ST_CONV_HI: begin
                    if (conv_done) begin
                        disp_hi_reg <= conv_bcd;
                        ovf_hi_reg  <= ovf_pend_reg;
                        state_reg   <= ST_LOAD_LO;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    logic [7:0] glyph [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_digit
            localparam int K     = gi % FIELD_DIGITS;
            localparam bit IS_HI = (gi >= FIELD_DIGITS);

            logic [BCD_W-1:0] field_bcd;
            logic             field_ovf;
            logic             field_blank;
            logic             zero_above;
            logic             lead_zero;
            logic [7:0]       base;

            assign field_bcd   = IS_HI ? disp_hi_reg : disp_lo_reg;
            assign field_ovf   = IS_HI ? ovf_hi_reg  : ovf_lo_reg;
            assign field_blank = IS_HI ? blank_hi    : blank_lo;
            // This digit and every more-significant digit of its field are zero
            assign zero_above  = (field_bcd >> (4 * K)) == '0;
            assign lead_zero   = field_blank && (K != 0) && zero_above;
            assign base        = field_ovf ? GLYPH_DASH :
                                 lead_zero ? GLYPH_BLANK :
                                 bcd_glyph(field_bcd[4*K +: 4]);
            assign glyph[gi]   = {base[7] & ~dp_mask[gi], base[6:0]};
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] lit_idx_reg;
    logic             lit_valid_reg;

    // idx_reg is the next digit to light; lit_idx_reg drives the pins one cycle after the wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            idx_reg       <= '0;
            lit_idx_reg   <= '0;
            lit_valid_reg <= 1'b0;
            an            <= '1;
            seg           <= GLYPH_BLANK;
        end else if (enable) begin
            if (cnt_reg == CNT_W'(SCAN_TICKS - 1)) begin
                cnt_reg       <= '0;
                lit_idx_reg   <= idx_reg;
                lit_valid_reg <= 1'b1;
                idx_reg       <= (idx_reg == IDX_W'(N - 1)) ? '0 : idx_reg + IDX_W'(1);
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (lit_valid_reg) begin
                an  <= ~(N'(1) << lit_idx_reg);
                seg <= glyph[lit_idx_reg];
            end else begin
                an  <= '1;
                seg <= GLYPH_BLANK;
            end
        end else begin
            an  <= '1;
            seg <= GLYPH_BLANK;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: expected digit glyphs are queued per scan
// and compared as the DUT walks the anodes.
module tb_seg_scan_driver;

    localparam int FD = 4;
    localparam int VW = 32;
    localparam int ST = 4;
    localparam int N  = 2 * FD;
    localparam int SETTLE = 160;
    localparam int UPDATE_BOUND = 150;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b1;
    logic [VW-1:0] value_lo = '0;
    logic [VW-1:0] value_hi = '0;
    logic          blank_lo = 1'b0;
    logic          blank_hi = 1'b0;
    logic [N-1:0]  dp_mask = '0;
    logic [7:0]    seg;
    logic [N-1:0]  an;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;
    exp_t sb[$];

    seg_scan_driver #(
        .FIELD_DIGITS (FD),
        .VALUE_W      (VW),
        .SCAN_TICKS   (ST)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .value_lo (value_lo),
        .value_hi (value_hi),
        .blank_lo (blank_lo),
        .blank_hi (blank_hi),
        .dp_mask  (dp_mask),
        .seg      (seg),
        .an       (an)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] exp_glyph(int unsigned v, bit blank, bit dp, int k);
        int unsigned p;
        logic [7:0] g;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v > 9999) g = 8'hBF;
        else if (blank && k != 0 && v < p) g = 8'hFF;
        else begin
            case ((v / p) % 10)
                0: g = 8'hC0;  1: g = 8'hF9;  2: g = 8'hA4;  3: g = 8'hB0;
                4: g = 8'h99;  5: g = 8'h92;  6: g = 8'h82;  7: g = 8'hF8;
                8: g = 8'h80;  default: g = 8'h90;
            endcase
        end
        if (dp) g[7] = 1'b0;
        return g;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_scan(input int unsigned lo, input int unsigned hi,
                             input bit blo, input bit bhi, input logic [N-1:0] dp);
        exp_t e;
        logic [7:0] one;
        for (int i = 0; i < N; i++) begin
            one = 8'h01;
            e.an  = ~(one << i);
            e.seg = (i < FD) ? exp_glyph(lo, blo, dp[i], i) : exp_glyph(hi, bhi, dp[i], i - FD);
            sb.push_back(e);
        end
    endtask

    task automatic wait_an(input logic [7:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (an === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_scan(input string tag);
        bit ok;
        exp_t e;
        wait_an(8'hFE, 200, ok);
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s start: observed no an=FE, expected an=FE within 200 cycles", tag);
        end
        if (!ok) begin
            sb.delete();
            return;
        end
        for (int i = 0; i < N; i++) begin
            e = sb.pop_front();
            check8($sformatf("%s d%0d an", tag, i), an, e.an);
            check8($sformatf("%s d%0d seg", tag, i), seg, e.seg);
            $display("%s digit %0d: an=%h seg=%h (exp an=%h seg=%h)", tag, i, an, seg, e.an, e.seg);
            repeat (ST) @(negedge clock);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit found;
        logic [7:0] an_before;
        logic [7:0] old_g;
        logic [7:0] new_g;

        #1 reset = 1'b1;
        #1;
        check8("power-on reset an", an, 8'hFF);
        check8("power-on reset seg", seg, 8'hFF);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        repeat (10) @(posedge clock);

        // Reset mid-scan
        @(negedge clock) reset = 1'b1;
        #1;
        check8("mid-scan reset an", an, 8'hFF);
        check8("mid-scan reset seg", seg, 8'hFF);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        for (int c = 1; c <= ST + 1; c++) begin
            @(posedge clock);
            #1;
            if (c == ST) check8("an before first light", an, 8'hFF);
            if (c == ST + 1) check8("first light an", an, 8'hFE);
        end
        $display("reset: first digit lit at cycle %0d", ST + 1);

        value_lo = 1234; value_hi = 56;
        repeat (SETTLE) @(posedge clock);
        push_scan(1234, 56, 0, 0, '0);
        check_scan("plain");

        blank_hi = 1'b1;
        repeat (SETTLE) @(posedge clock);
        push_scan(1234, 56, 0, 1, '0);
        check_scan("blank_hi");

        value_hi = 0;
        repeat (SETTLE) @(posedge clock);
        push_scan(1234, 0, 0, 1, '0);
        check_scan("zero_hi");

        value_hi = 10000; value_lo = 9999; blank_hi = 1'b0;
        repeat (SETTLE) @(posedge clock);
        push_scan(9999, 10000, 0, 0, '0);
        check_scan("ovf");

        value_hi = 56; value_lo = 1234; dp_mask = 8'h10;
        repeat (SETTLE) @(posedge clock);
        push_scan(1234, 56, 0, 0, 8'h10);
        check_scan("dp");

        // Enable low holds the scan position
        wait_an(8'hFB, 200, ok);
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL enable pre: observed no an=FB, expected an=FB");
        end
        an_before = an;
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            check8("disabled an", an, 8'hFF);
            check8("disabled seg", seg, 8'hFF);
        end
        @(negedge clock) enable = 1'b1;
        @(posedge clock);
        #1;
        check8("resume an", an, an_before);
        $display("enable: resumed on an=%h", an);
        for (int c = 0; c < 2 * ST; c++) begin
            @(negedge clock);
            if (an !== an_before) break;
        end
        check8("resume next an", an, 8'hF7);

        // Value change while the converter is busy
        dp_mask = '0;
        value_lo = 1999;
        repeat (SETTLE) @(posedge clock);
        push_scan(1999, 56, 0, 0, '0);
        check_scan("pre-change");
        repeat (23) @(posedge clock);
        @(negedge clock) value_lo = 2000;
        found = 1'b0;
        for (int c = 0; c < UPDATE_BOUND; c++) begin
            @(negedge clock);
            for (int k = 0; k < FD; k++) begin
                if (an[k] === 1'b0) begin
                    old_g = exp_glyph(1999, 0, 0, k);
                    new_g = exp_glyph(2000, 0, 0, k);
                    checks++;
                    assert (seg === old_g || seg === new_g) else begin
                        errors++;
                        $error("FAIL transition d%0d: observed %h expected %h or %h", k, seg, old_g, new_g);
                    end
                    if (k == FD - 1 && seg === new_g) found = 1'b1;
                end
            end
            if (found) break;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL update latency: observed no 2000 on d3, expected within %0d cycles", UPDATE_BOUND);
        end
        push_scan(2000, 56, 0, 0, '0);
        check_scan("post-change");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
